io_hub: RTL and testbench

Parametrised multi-hart memory-mapped IO hub that sits between the CPU's per-hart IO ports and a single byte-wide UART transmitter. Each hart gets its own TX FIFO, so simultaneous console writes are never lost or merged. A round-robin arbiter drains the FIFOs into one valid/ready byte stream. The hub also owns the shared LED register and the per-hart halt flags, and returns per-hart status on the IO read path.

---
 rtl/io_hub.sv | 172 +++++++++++++++++
 tb/tb_io_hub.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_hub.sv
// Multi-hart IO hub: one TX FIFO per hart drained round-robin into a single
// valid/ready byte stream, plus the shared LED register and per-hart halt flags.

module io_hub_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][7:0] mem;
    logic [AW-1:0]         wptr, rptr;
    logic [AW:0]           cnt;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign dout  = mem[rptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end
endmodule

module io_hub #(
    parameter int NPORTS     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NPORTS-1:0]    io_wr,
    input  logic [32*NPORTS-1:0] io_addr,
    input  logic [32*NPORTS-1:0] io_wdata,
    output logic [32*NPORTS-1:0] io_rdata,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [7:0]           leds,
    output logic [NPORTS-1:0]    halted,
    output logic                 halt
);
    localparam int LW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [NPORTS-1:0]      sel_led, sel_data, sel_stat, sel_halt;
    logic [NPORTS-1:0]      push, pop, full, empty, ovf;
    logic [NPORTS-1:0]      unused_bits;
    logic [NPORTS-1:0][7:0] fifo_dout;
    logic [LW-1:0]          last_grant, grant;
    logic                   any_ne, load;

    genvar p;
    generate
        for (p = 0; p < NPORTS; p++) begin : g_port
            // Word-address bits 0..3 each select one function independently.
            assign sel_led[p]  = io_addr[p*32 + 2];
            assign sel_data[p] = io_addr[p*32 + 3];
            assign sel_stat[p] = io_addr[p*32 + 4];
            assign sel_halt[p] = io_addr[p*32 + 5];
            assign unused_bits[p] = ^{io_addr[p*32 +: 2], io_addr[p*32+6 +: 26],
                                      io_wdata[p*32+8 +: 24]};

            assign push[p] = io_wr[p] & sel_data[p] & ~full[p];
            assign pop[p]  = load & (grant == LW'(p));

            io_hub_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
                .clk    (clk),
                .resetn (resetn),
                .push   (push[p]),
                .din    (io_wdata[p*32 +: 8]),
                .pop    (pop[p]),
                .dout   (fifo_dout[p]),
                .full   (full[p]),
                .empty  (empty[p])
            );

            // Set wins over a same-cycle clear so a drop is never hidden.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)
                    ovf[p] <= 1'b0;
                else if (io_wr[p] & sel_data[p] & full[p])
                    ovf[p] <= 1'b1;
                else if (io_wr[p] & sel_stat[p])
                    ovf[p] <= 1'b0;
            end

            assign io_rdata[p*32 +: 32] = sel_stat[p] ?
                {20'b0, ovf[p], empty[p], full[p], 9'b0} : 32'b0;
        end
    endgenerate

    // Round-robin: first non-empty FIFO after the last one served.
    always_comb begin
        int idx;
        logic found;
        grant = last_grant;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NPORTS; i++) begin
            idx = (int'(last_grant) + i) % NPORTS;
            if (!found && !empty[idx]) begin
                grant = LW'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_ne = |(~empty);
    assign load   = any_ne & (~tx_valid | tx_ready);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            last_grant <= LW'(NPORTS - 1);
        end else if (load) begin
            tx_valid   <= 1'b1;
            tx_data    <= fifo_dout[grant];
            last_grant <= grant;
        end else if (tx_ready) begin
            tx_valid   <= 1'b0;
        end
    end

    // Lowest-index writer wins the shared LED register.
    logic       led_we;
    logic [7:0] led_nxt;
    always_comb begin
        led_we  = 1'b0;
        led_nxt = leds;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (io_wr[i] && sel_led[i]) begin
                led_we  = 1'b1;
                led_nxt = io_wdata[i*32 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            leds   <= '0;
            halted <= '0;
        end else begin
            if (led_we) leds <= led_nxt;
            halted <= halted | (io_wr & sel_halt);
        end
    end

    assign halt = |halted;
endmodule

// File: tb/tb_io_hub.sv
// Scoreboard bench for io_hub: stimulus queues expected bytes, a negedge
// monitor pops and compares them at every output handshake.

module tb_io_hub;
    localparam int NP = 2;
    localparam int DEPTH = 8;
    localparam logic [31:0] A_LED = 32'h04, A_DATA = 32'h08, A_STAT = 32'h10, A_HALT = 32'h20;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [NP-1:0]    io_wr = '0;
    logic [32*NP-1:0] io_addr = '0;
    logic [32*NP-1:0] io_wdata = '0;
    logic [32*NP-1:0] io_rdata;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
    logic [7:0]       leds;
    logic [NP-1:0]    halted;
    logic             halt;

    io_hub #(.NPORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .io_wr(io_wr), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .leds(leds),
        .halted(halted), .halt(halt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Directed tests predict the global output order; the random test tags
    // each byte with its port in bit 7 and checks per-port order.
    bit         tag_mode = 1'b0;
    logic [7:0] exp_all[$];
    logic [7:0] exp_p0[$];
    logic [7:0] exp_p1[$];
    int         pushed[2];
    int         popped[2];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic put(int p, logic [31:0] a, logic [31:0] d);
        io_wr[p] = 1'b1;
        io_addr[p*32 +: 32] = a;
        io_wdata[p*32 +: 32] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        io_wr = '0;
    endtask

    task automatic rd_stat(int p, output logic [31:0] v);
        io_addr[p*32 +: 32] = A_STAT;
        #1;
        v = io_rdata[p*32 +: 32];
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        io_wr = '0;
        tx_ready = 1'b0;
        exp_all.delete();
        exp_p0.delete();
        exp_p1.delete();
        pushed = '{0, 0};
        popped = '{0, 0};
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(int budget);
        int left;
        for (int c = 0; c < budget; c++) begin
            if (exp_all.size() == 0 && exp_p0.size() == 0 && exp_p1.size() == 0) break;
            @(posedge clk);
            #1;
        end
        left = exp_all.size() + exp_p0.size() + exp_p1.size();
        chk("drain_timeout", left, 0);
    endtask

    // Monitor: handshake sampled at negedge completes on the next posedge.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    always @(negedge clk) begin
        if (!resetn) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", tx_valid, 1'b1);
                chk("stall_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                if (tag_mode) begin
                    if (tx_data[7]) begin
                        if (exp_p1.size() == 0) chk("spurious_p1", 1, 0);
                        else chk("p1_byte", tx_data, exp_p1.pop_front());
                        popped[1]++;
                    end else begin
                        if (exp_p0.size() == 0) chk("spurious_p0", 1, 0);
                        else chk("p0_byte", tx_data, exp_p0.pop_front());
                        popped[0]++;
                    end
                end else begin
                    if (exp_all.size() == 0) chk("spurious", 1, 0);
                    else chk("out_byte", tx_data, exp_all.pop_front());
                end
            end
            prev_stall <= tx_valid && !tx_ready;
            prev_data  <= tx_data;
        end
    end

    initial begin
        logic [31:0] st;
        logic [7:0]  d;
        int          sent, cyc;
        int          seq[2];

        // Reset state
        do_reset();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_leds", leds, 0);
        chk("rst_halted", halted, 0);
        chk("rst_halt", halt, 0);
        rd_stat(0, st);
        chk("rst_stat0", st, 32'h400);
        rd_stat(1, st);
        chk("rst_stat1", st, 32'h400);

        // Single byte: valid two edges after the write, for one cycle
        tx_ready = 1'b1;
        put(0, A_DATA, 32'h41);
        exp_all.push_back(8'h41);
        step();
        chk("single_v_e0", tx_valid, 0);
        rd_stat(0, st);
        chk("single_stat_e0", st, 32'h000);
        step();
        chk("single_v_e1", tx_valid, 1);
        chk("single_d_e1", tx_data, 8'h41);
        step();
        chk("single_v_e2", tx_valid, 0);
        rd_stat(0, st);
        chk("single_stat_end", st, 32'h400);

        // Simultaneous writes: port 0 first, back-to-back
        do_reset();
        tx_ready = 1'b1;
        put(0, A_DATA, 32'h30);
        put(1, A_DATA, 32'h31);
        exp_all.push_back(8'h30);
        exp_all.push_back(8'h31);
        step();
        chk("simul_v_e0", tx_valid, 0);
        step();
        chk("simul_v_e1", tx_valid, 1);
        chk("simul_d_e1", tx_data, 8'h30);
        step();
        chk("simul_v_e2", tx_valid, 1);
        chk("simul_d_e2", tx_data, 8'h31);
        step();
        chk("simul_v_e3", tx_valid, 0);

        // Round-robin fairness: strict alternation, then port 0 alone
        do_reset();
        for (int i = 0; i < 4; i++) begin
            put(0, A_DATA, 32'h00 + i);
            put(1, A_DATA, 32'h80 + i);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            exp_all.push_back(8'(8'h00 + i));
            exp_all.push_back(8'(8'h80 + i));
        end
        tx_ready = 1'b1;
        wait_drain(40);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(0, A_DATA, 32'h10 + i);
            exp_all.push_back(8'(8'h10 + i));
            step();
        end
        tx_ready = 1'b1;
        wait_drain(40);

        // Overflow: 10 writes into 8 FIFO slots plus the output register
        do_reset();
        for (int i = 0; i < 10; i++) begin
            put(1, A_DATA, 32'h50 + i);
            if (i < 9) exp_all.push_back(8'(8'h50 + i));
            step();
        end
        rd_stat(1, st);
        chk("ovf_stat_full", st, 32'hA00);
        rd_stat(0, st);
        chk("ovf_stat_p0", st, 32'h400);
        tx_ready = 1'b1;
        wait_drain(40);
        repeat (2) step();
        rd_stat(1, st);
        chk("ovf_stat_drained", st, 32'hC00);
        put(1, A_STAT, 32'h0);
        step();
        rd_stat(1, st);
        chk("ovf_cleared", st, 32'h400);

        // Random backpressure, 100 tagged bytes from two ports
        do_reset();
        tag_mode = 1'b1;
        sent = 0;
        cyc = 0;
        seq = '{0, 0};
        while (sent < 100 && cyc < 5000) begin
            tx_ready = 1'($urandom_range(0, 1));
            for (int p = 0; p < NP; p++) begin
                if (sent < 100 && $urandom_range(0, 1) == 1 && (pushed[p] - popped[p]) < DEPTH - 1) begin
                    d = {p[0], 7'(seq[p])};
                    put(p, A_DATA, {24'h0, d});
                    if (p == 0) exp_p0.push_back(d);
                    else exp_p1.push_back(d);
                    pushed[p]++;
                    seq[p]++;
                    sent++;
                end
            end
            step();
            cyc++;
        end
        chk("rand_sent", sent, 100);
        tx_ready = 1'b1;
        wait_drain(400);
        chk("rand_count0", popped[0], pushed[0]);
        chk("rand_count1", popped[1], pushed[1]);
        tag_mode = 1'b0;

        // LEDs, halt, asynchronous reset mid-transfer
        do_reset();
        put(0, A_LED, 32'h0F);
        put(1, A_LED, 32'hF0);
        chk("led_before_edge", leds, 0);
        step();
        chk("led_priority", leds, 8'h0F);
        put(1, A_HALT, 32'h0);
        step();
        chk("halted_p1", halted, 2'b10);
        chk("halt_or", halt, 1);
        put(0, A_DATA, 32'h77);
        exp_all.push_back(8'h77);
        step();
        step();
        chk("inflight_v", tx_valid, 1);
        chk("inflight_d", tx_data, 8'h77);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_tx_valid", tx_valid, 0);
        chk("async_tx_data", tx_data, 0);
        chk("async_leds", leds, 0);
        chk("async_halted", halted, 0);
        chk("async_halt", halt, 0);
        do_reset();
        rd_stat(0, st);
        chk("post_rst_stat", st, 32'h400);
        repeat (3) step();
        chk("post_rst_valid", tx_valid, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
